// File: rtl/i2c_slave_regfile.sv
// -----------------------------------------------------------------------------
// i2c_slave_regfile
// I2C target with a small byte-wide register file. It decodes START/STOP,
// answers device address SLV_ADDR and accepts write frames:
// a register pointer byte, then data bytes with pointer auto-increment.
// Every accepted data byte updates the register file and pulses wr_en.
//
// Build option: define I2C_SLV_READ_EN to compile in read support. A matched
// address with R/W=1 then streams reg[ptr] back to the master. When the macro
// is undefined, R/W=1 is NACKed.
//
// Ports
//   sys_clk, sys_rst  : clock, synchronous active-high reset
//   i2c_scl_i         : SCL pad input (asynchronous)
//   i2c_sda_i         : SDA pad input (asynchronous)
//   i2c_sda_oe        : 1 = pull SDA low (open-drain enable)
//   wr_en             : one-cycle strobe per accepted data byte
//   wr_addr, wr_data  : register index and byte of that write
//   host_addr         : local read port address
//   host_rdata        : reg[host_addr], registered, 1-cycle latency
//   busy              : high from address match until STOP
//   frame_done        : one-cycle pulse on STOP that ends an addressed frame
// -----------------------------------------------------------------------------
module i2c_slave_regfile #(
  parameter logic [6:0] SLV_ADDR = 7'h1A,
  parameter int         REG_AW   = 4,
  parameter int         FILT_LEN = 3
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              i2c_scl_i,
  input  logic              i2c_sda_i,
  output logic              i2c_sda_oe,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic [REG_AW-1:0] host_addr,
  output logic [7:0]        host_rdata,
  output logic              busy,
  output logic              frame_done
);

  localparam int DEPTH = 1 << REG_AW;
  localparam int CW    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK, S_WDATA, S_WDATA_ACK, S_IGNORE
`ifdef I2C_SLV_READ_EN
    , S_RDATA, S_RDATA_ACK
`endif
  } state_t;

  // ---------------- input conditioning: bit 0 = SCL, bit 1 = SDA ----------
  logic [1:0] w_pad;
  logic [1:0] w_filt;
  assign w_pad = {i2c_sda_i, i2c_scl_i};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cond
      logic          r_s1, r_s2, r_f;
      logic [CW-1:0] r_cnt;
      // The filtered level follows the synchronized one only after it has
      // disagreed for FILT_LEN consecutive cycles.
      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          r_s1  <= 1'b0;
          r_s2  <= 1'b0;
          r_f   <= 1'b0;
          r_cnt <= '0;
        end else begin
          r_s1 <= w_pad[gi];
          r_s2 <= r_s1;
          if (r_s2 == r_f) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_f   <= r_s2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
      assign w_filt[gi] = r_f;
    end
  endgenerate

  logic w_scl_f, w_sda_f, r_scl_prev, r_sda_prev;
  assign w_scl_f = w_filt[0];
  assign w_sda_f = w_filt[1];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_scl_prev <= 1'b0;
      r_sda_prev <= 1'b0;
    end else begin
      r_scl_prev <= w_scl_f;
      r_sda_prev <= w_sda_f;
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = w_scl_f & ~r_scl_prev;
  assign w_scl_fall = ~w_scl_f & r_scl_prev;
  // SCL must be high in both cycles so an SCL edge is never taken as START/STOP.
  assign w_start = w_scl_f & r_scl_prev & ~w_sda_f & r_sda_prev;
  assign w_stop  = w_scl_f & r_scl_prev & w_sda_f & ~r_sda_prev;

  // ---------------- datapath signals ----------------
  state_t            r_state, w_state_next, r_after_ack;
  logic [2:0]        r_bit_cnt;
  logic [6:0]        r_shift;
  logic [REG_AW-1:0] r_ptr;
  logic              r_ack, r_ack_seen;
  logic [7:0]        w_byte;
  logic              w_last_bit, w_addr_match, w_reg_ok, w_mem_we;
  logic [7:0]        w_mem [DEPTH];

  assign w_byte       = {r_shift, w_sda_f};
  assign w_last_bit   = w_scl_rise && (r_bit_cnt == 3'd7);
  assign w_addr_match = (w_byte[7:1] == SLV_ADDR);
  assign w_reg_ok     = ((w_byte >> REG_AW) == 8'd0);
  assign w_mem_we     = (r_state == S_WDATA) && w_last_bit;

`ifdef I2C_SLV_READ_EN
  logic [7:0]        r_tx;
  logic [REG_AW-1:0] w_rd_ptr;
  logic [7:0]        w_rd_byte;
  // Leaving RDATA_ACK after a master ACK moves on to the next register.
  assign w_rd_ptr  = (r_state == S_RDATA_ACK) ? r_ptr + 1'b1 : r_ptr;
  assign w_rd_byte = w_mem[w_rd_ptr];
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_stop) begin
      w_state_next = S_IDLE;
    end else if (w_start) begin
      w_state_next = S_ADDR;
    end else begin
      case (r_state)
        S_ADDR:  if (w_last_bit) w_state_next = S_ADDR_ACK;
        S_REG:   if (w_last_bit) w_state_next = S_REG_ACK;
        S_WDATA: if (w_last_bit) w_state_next = S_WDATA_ACK;
`ifdef I2C_SLV_READ_EN
        S_RDATA: if (w_last_bit) w_state_next = S_RDATA_ACK;
        S_RDATA_ACK,
`endif
        S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK:
          if (w_scl_fall && r_ack_seen) w_state_next = r_after_ack;
        default: ;
      endcase
    end
  end

  // ---------------- bit engine, SDA drive, write strobe ----------------
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      i2c_sda_oe  <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_ack       <= 1'b0;
      r_ack_seen  <= 1'b0;
      r_after_ack <= S_IDLE;
`ifdef I2C_SLV_READ_EN
      r_tx        <= '0;
`endif
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      if (w_stop) begin
        i2c_sda_oe <= 1'b0;
        r_bit_cnt  <= '0;
        frame_done <= busy;
        busy       <= 1'b0;
      end else if (w_start) begin
        i2c_sda_oe <= 1'b0;
        r_bit_cnt  <= '0;
      end else begin
        case (r_state)
          S_ADDR, S_REG, S_WDATA: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_ack_seen <= 1'b0;
                case (r_state)
                  S_ADDR: begin
                    if (w_addr_match && !w_byte[0]) begin
                      r_ack       <= 1'b1;
                      busy        <= 1'b1;
                      r_after_ack <= S_REG;
`ifdef I2C_SLV_READ_EN
                    end else if (w_addr_match) begin
                      r_ack       <= 1'b1;
                      busy        <= 1'b1;
                      r_after_ack <= S_RDATA;
`endif
                    end else begin
                      r_ack       <= 1'b0;
                      r_after_ack <= S_IGNORE;
                    end
                  end
                  S_REG: begin
                    if (w_reg_ok) begin
                      r_ptr       <= w_byte[REG_AW-1:0];
                      r_ack       <= 1'b1;
                      r_after_ack <= S_WDATA;
                    end else begin
                      r_ack       <= 1'b0;
                      r_after_ack <= S_IGNORE;
                    end
                  end
                  default: begin
                    wr_en       <= 1'b1;
                    wr_addr     <= r_ptr;
                    wr_data     <= w_byte;
                    r_ptr       <= r_ptr + 1'b1;
                    r_ack       <= 1'b1;
                    r_after_ack <= S_WDATA;
                  end
                endcase
              end
            end
          end
`ifdef I2C_SLV_READ_EN
          S_RDATA: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_ack      <= 1'b0;   // master owns SDA in the ACK slot
                r_ack_seen <= 1'b0;
              end
            end
            if (w_scl_fall) begin
              i2c_sda_oe <= ~r_tx[6];
              r_tx       <= {r_tx[6:0], 1'b0};
            end
          end
          S_RDATA_ACK,
`endif
          S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
            // First SCL fall (end of bit 8) drives the ACK; the rise is the
            // 9th clock; the following fall releases SDA and leaves the state.
            if (w_scl_rise) begin
              r_ack_seen <= 1'b1;
`ifdef I2C_SLV_READ_EN
              if (r_state == S_RDATA_ACK)
                r_after_ack <= w_sda_f ? S_IGNORE : S_RDATA;
`endif
            end
            if (w_scl_fall) begin
              if (!r_ack_seen) begin
                i2c_sda_oe <= r_ack;
              end else begin
                i2c_sda_oe <= 1'b0;
`ifdef I2C_SLV_READ_EN
                if (r_after_ack == S_RDATA) begin
                  r_ptr      <= w_rd_ptr;
                  r_tx       <= w_rd_byte;
                  i2c_sda_oe <= ~w_rd_byte[7];
                end
`endif
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- register file ----------------
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      logic [7:0] r_byte;
      always_ff @(posedge sys_clk) begin
        if (sys_rst)                                     r_byte <= '0;
        else if (w_mem_we && (r_ptr == REG_AW'(gi)))     r_byte <= w_byte;
      end
      assign w_mem[gi] = r_byte;
    end
  endgenerate

  always_ff @(posedge sys_clk) begin
    if (sys_rst) host_rdata <= '0;
    else         host_rdata <= w_mem[host_addr];
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// -----------------------------------------------------------------------------
// tb_i2c_slave_regfile
// Directed bench: a bit-banged I2C master drives the target through write
// frames, address/register rejection, partial bytes, a mid-frame reset and
// (with I2C_SLV_READ_EN) a read-back. Expected values are hand computed.
// -----------------------------------------------------------------------------
module tb_i2c_slave_regfile;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [3:0] host_addr = 4'd0;

  logic       sda_oe, wr_en, busy, frame_done;
  logic [3:0] wr_addr;
  logic [7:0] wr_data, host_rdata;
  logic       sda_line;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_regfile #(.SLV_ADDR(7'h1A), .REG_AW(4), .FILT_LEN(3)) dut (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .i2c_scl_i  (scl_m),
    .i2c_sda_i  (sda_line),
    .i2c_sda_oe (sda_oe),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .host_addr  (host_addr),
    .host_rdata (host_rdata),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Event monitors (free running; the test takes differences of snapshots)
  int         wr_cnt = 0;
  int         fd_cnt = 0;
  int         busy_cyc = 0;
  logic [3:0] last_addr = 4'd0;
  logic [7:0] last_data = 8'd0;

  always @(posedge clk) begin
    if (wr_en) begin
      wr_cnt    <= wr_cnt + 1;
      last_addr <= wr_addr;
      last_data <= wr_data;
      $display("txn: wr_en addr=%0d data=%02h", wr_addr, wr_data);
    end
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (busy)       busy_cyc <= busy_cyc + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // ---------------- bit-banged master ----------------
  task automatic wq();
    repeat (10) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1; wq();
    $display("txn: STOP");
  endtask

  task automatic put_bit(input logic b);
    sda_m = b;    wq();
    scl_m = 1'b1; wq(); wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    b = sda_line; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic put_byte(input logic [7:0] v, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(v[i]);
    get_bit(b);
    ack = ~b;
    $display("txn: byte %02h ack=%0d", v, ack);
  endtask

  task automatic get_byte(output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      v[i] = b;
    end
    $display("txn: read byte %02h", v);
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    host_addr = a;
    @(negedge clk);
    @(negedge clk);
    d = host_rdata;
    $display("txn: host read reg%0d = %02h", a, d);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         w0, f0, b0;

    // ---- reset state ----
    repeat (5) @(negedge clk);
    chk("rst_oe",    32'(sda_oe),     32'd0);
    chk("rst_wr_en", 32'(wr_en),      32'd0);
    chk("rst_waddr", 32'(wr_addr),    32'd0);
    chk("rst_wdata", 32'(wr_data),    32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_fdone", 32'(frame_done), 32'd0);
    chk("rst_rdata", 32'(host_rdata), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // ---- single write: reg5 = A5 ----
    w0 = wr_cnt; f0 = fd_cnt;
    bus_start();
    put_byte(8'h34, ack); chk("w1_addr_ack", 32'(ack), 32'd1);
    put_byte(8'h05, ack); chk("w1_reg_ack",  32'(ack), 32'd1);
    put_byte(8'hA5, ack); chk("w1_dat_ack",  32'(ack), 32'd1);
    chk("w1_busy", 32'(busy), 32'd1);
    bus_stop();
    repeat (5) @(negedge clk);
    chk("w1_wr_cnt", 32'(wr_cnt - w0), 32'd1);
    chk("w1_waddr",  32'(last_addr),   32'd5);
    chk("w1_wdata",  32'(last_data),   32'hA5);
    chk("w1_fdone",  32'(fd_cnt - f0), 32'd1);
    chk("w1_busy_after", 32'(busy),    32'd0);
    rd_reg(4'd5, d); chk("w1_reg5", 32'(d), 32'hA5);

    // ---- burst with pointer wrap: reg14/15/0 ----
    w0 = wr_cnt;
    bus_start();
    put_byte(8'h34, ack);
    put_byte(8'h0E, ack);
    put_byte(8'h11, ack); chk("b_ack0", 32'(ack), 32'd1);
    put_byte(8'h22, ack); chk("b_ack1", 32'(ack), 32'd1);
    put_byte(8'h33, ack); chk("b_ack2", 32'(ack), 32'd1);
    bus_stop();
    repeat (5) @(negedge clk);
    chk("b_wr_cnt", 32'(wr_cnt - w0), 32'd3);
    chk("b_last_addr", 32'(last_addr), 32'd0);
    rd_reg(4'd14, d); chk("b_reg14", 32'(d), 32'h11);
    rd_reg(4'd15, d); chk("b_reg15", 32'(d), 32'h22);
    rd_reg(4'd0,  d); chk("b_reg0",  32'(d), 32'h33);

    // ---- foreign address 0x36 ----
    w0 = wr_cnt; f0 = fd_cnt; b0 = busy_cyc;
    bus_start();
    put_byte(8'h36, ack); chk("na_addr_ack", 32'(ack), 32'd0);
    put_byte(8'h01, ack); chk("na_reg_ack",  32'(ack), 32'd0);
    bus_stop();
    repeat (5) @(negedge clk);
    chk("na_wr_cnt",   32'(wr_cnt - w0),   32'd0);
    chk("na_busy_cyc", 32'(busy_cyc - b0), 32'd0);
    chk("na_fdone",    32'(fd_cnt - f0),   32'd0);
    bus_start();
    put_byte(8'h34, ack); chk("na2_addr_ack", 32'(ack), 32'd1);
    put_byte(8'h01, ack);
    put_byte(8'h77, ack); chk("na2_dat_ack", 32'(ack), 32'd1);
    bus_stop();
    rd_reg(4'd1, d); chk("na2_reg1", 32'(d), 32'h77);

    // ---- register pointer out of range ----
    w0 = wr_cnt; f0 = fd_cnt;
    bus_start();
    put_byte(8'h34, ack); chk("rr_addr_ack", 32'(ack), 32'd1);
    put_byte(8'h20, ack); chk("rr_reg_ack",  32'(ack), 32'd0);
    put_byte(8'h99, ack); chk("rr_dat_ack",  32'(ack), 32'd0);
    bus_stop();
    repeat (5) @(negedge clk);
    chk("rr_wr_cnt", 32'(wr_cnt - w0), 32'd0);
    chk("rr_fdone",  32'(fd_cnt - f0), 32'd1);

    // ---- STOP after 4 data bits ----
    w0 = wr_cnt;
    bus_start();
    put_byte(8'h34, ack);
    put_byte(8'h02, ack);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
    bus_stop();
    repeat (5) @(negedge clk);
    chk("ps_wr_cnt", 32'(wr_cnt - w0), 32'd0);
    chk("ps_busy",   32'(busy),        32'd0);
    rd_reg(4'd2, d); chk("ps_reg2", 32'(d), 32'h00);

    // ---- reset mid-byte ----
    bus_start();
    put_byte(8'h34, ack);
    put_byte(8'h03, ack);
    put_bit(1'b1); put_bit(1'b1); put_bit(1'b0); put_bit(1'b0);
    chk("mr_busy_before", 32'(busy), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    @(negedge clk);
    $display("txn: sys_rst pulse");
    chk("mr_oe",    32'(sda_oe),     32'd0);
    chk("mr_busy",  32'(busy),       32'd0);
    chk("mr_waddr", 32'(wr_addr),    32'd0);
    chk("mr_wdata", 32'(wr_data),    32'd0);
    chk("mr_rdata", 32'(host_rdata), 32'd0);
    rd_reg(4'd5, d);  chk("mr_reg5",  32'(d), 32'h00);
    rd_reg(4'd14, d); chk("mr_reg14", 32'(d), 32'h00);
    bus_stop();
    w0 = wr_cnt;
    bus_start();
    put_byte(8'h34, ack); chk("mr2_addr_ack", 32'(ack), 32'd1);
    put_byte(8'h03, ack);
    put_byte(8'h5A, ack); chk("mr2_dat_ack", 32'(ack), 32'd1);
    bus_stop();
    repeat (5) @(negedge clk);
    chk("mr2_wr_cnt", 32'(wr_cnt - w0), 32'd1);
    rd_reg(4'd3, d); chk("mr2_reg3", 32'(d), 32'h5A);

    // ---- pointer set, repeated START, read address ----
    f0 = fd_cnt; w0 = wr_cnt;
    bus_start();
    put_byte(8'h34, ack);
    put_byte(8'h03, ack); chk("rd_reg_ack", 32'(ack), 32'd1);
    bus_start();
`ifdef I2C_SLV_READ_EN
    put_byte(8'h35, ack); chk("rd_addr_ack", 32'(ack), 32'd1);
    get_byte(d);
    put_bit(1'b1);        // master NACK
    chk("rd_data", 32'(d), 32'h5A);
`else
    put_byte(8'h35, ack); chk("rd_addr_nack", 32'(ack), 32'd0);
`endif
    bus_stop();
    repeat (5) @(negedge clk);
    chk("rd_fdone",  32'(fd_cnt - f0), 32'd1);
    chk("rd_wr_cnt", 32'(wr_cnt - w0), 32'd0);
    chk("rd_busy",   32'(busy),        32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regfile.md
# i2c_slave_regfile

I2C target (responder) with an internal 8-bit register file, the receiving end of the design's I2C configuration master. It decodes START/STOP, matches a 7-bit device address, and accepts write frames: register pointer byte, then data bytes with pointer auto-increment. Each write reaches both the register file and a one-cycle strobe port. It emulates a configuration-target codec on-chip so the Nios-driven I2C write path can be closed in loopback, in the bench and on the board.

## Interface
- SLV_ADDR, 7'h1A: 7-bit device address answered.
- REG_AW, 4: register pointer width; the file holds 2^REG_AW bytes.
- FILT_LEN, 3: sys_clk cycles a synchronized SCL/SDA level must be stable before it is accepted.

- sys_clk, in, 1: system clock; SCL must be ≤ sys_clk/(4·(FILT_LEN+3)).
- sys_rst, in, 1: synchronous, active-high reset.
- i2c_scl_i, in, 1: SCL pad input; asynchronous.
- i2c_sda_i, in, 1: SDA pad input; asynchronous.
- i2c_sda_oe, out, 1: 1 = pull SDA low. The top level builds the open-drain pad as `I2C_SDAT = oe ? 0 : z`.
- wr_en, out, 1: one-cycle strobe per accepted data byte.
- wr_addr, out, REG_AW: register written.
- wr_data, out, 8: byte written.
- host_addr, in, REG_AW: local read port address.
- host_rdata, out, 8: reg[host_addr], registered, 1-cycle latency.
- busy, out, 1: high from address match until STOP.
- frame_done, out, 1: one-cycle pulse on STOP ending a frame that was addressed to this target.

## Operation
- Input conditioning:
  - 2-flop synchronizer, then FILT_LEN-deep glitch filter on each line.
  - The filtered signals scl_f and sda_f are edge-detected in sys_clk.
- Bus conditions:
  - START = sda_f falls while scl_f is high.
  - STOP = sda_f rises while scl_f is high.
  - Data bits are sampled on the scl_f rising edge, MSB first.
- FSM states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, IGNORE (plus RDATA and RDATA_ACK, see Configuration).
- IDLE → ADDR on START.
- ADDR → ADDR_ACK after 8 bits.
  - The byte matches when addr[7:1]==SLV_ADDR and R/W=0.
  - On a match: ACK, then REG.
  - Otherwise: no ACK, then IGNORE.
- REG → REG_ACK after 8 bits.
  - If byte < 2^REG_AW: load ptr, ACK, then WDATA.
  - Otherwise: NACK, then IGNORE.
- WDATA → WDATA_ACK after 8 bits.
  - reg[ptr] ← byte; wr_en pulses with wr_addr=ptr and wr_data=byte.
  - ptr ← ptr+1, wrapping modulo 2^REG_AW.
  - ACK, then WDATA.
- IGNORE: i2c_sda_oe stays 0 until the next START or STOP.
- Repeated START in any state: go to ADDR; the bit counter is cleared and ptr is kept.
- STOP in any state:
  - Go to IDLE and release SDA.
  - frame_done pulses if busy was high.
  - A partial byte is discarded and no write occurs.
- A START and a STOP are never detected in the same cycle: each needs its own SDA edge.
- Reset values:
  - Outputs: i2c_sda_oe=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, host_rdata=0.
  - Internal: all registers are 0, ptr=0, FSM in IDLE.
- Reset mid-frame: the target returns to IDLE immediately and SDA is released. The bus is rejoined only at the next START.

## Timing
- Input latency: pad edge to scl_f/sda_f edge is 2+FILT_LEN cycles.
- ACK drive:
  - i2c_sda_oe asserts 1 cycle after the scl_f falling edge that ends bit 8.
  - It is released 1 cycle after the next scl_f falling edge (after the 9th clock).
- wr_en asserts 1 cycle after the scl_f rising edge that samples bit 0 of a data byte.
- frame_done asserts 1 cycle after STOP is detected.
- SDA is changed by the target only on scl_f low, never while SCL is high.

## Configuration
- I2C_SLV_READ_EN defined: read support is compiled in.
  - A matched address with R/W=1 is ACKed and enters RDATA.
  - RDATA drives the inverse of reg[ptr] bits on i2c_sda_oe, MSB first, each bit changing 1 cycle after the scl_f falling edge.
  - RDATA_ACK samples the master ACK.
  - ACK: ptr+1, then RDATA.
  - NACK: IGNORE (wait for STOP or START).
- I2C_SLV_READ_EN undefined: the R/W=1 address byte is NACKed and the FSM goes to IGNORE. No RDATA logic is synthesized.

## Test plan
- Write 0x34, 0x05, 0xA5, then STOP → ACK on all three bytes; wr_en once with wr_addr=5, wr_data=0xA5; frame_done once; host_addr=5 gives host_rdata=0xA5.
- Burst 0x34, 0x0E, then 0x11, 0x22, 0x33 → reg14=0x11, reg15=0x22, reg0=0x33 (pointer wrap); three wr_en pulses.
- Address 0x36 → no ACK, no wr_en, busy stays 0; a following frame to 0x34 behaves normally.
- Register byte 0x20 with REG_AW=4 → NACK; a subsequent data byte is ignored, with no wr_en.
- STOP after 4 bits of a data byte → no write, busy=0. A sys_rst pulse mid-byte → all outputs and registers return to 0 and the next frame succeeds.
- With I2C_SLV_READ_EN: write reg3=0x5A, then repeated START, 0x35, read one byte with master NACK → the master samples 0x5A. Without the macro, 0x35 is NACKed.
